tlul_err_gate: RTL and testbench

- Sits between a TL-UL host port and a single device port, downstream of the A-channel legality checker.
- Forwards legal A requests to the device and tracks outstanding transactions.
- Absorbs illegal requests. For each one it waits until all earlier device responses have drained, then returns an in-order D-channel error response itself.
- Data, address and mask fields pass straight through outside this block; only control and response-header fields are handled here.

---
 rtl/tlul_err_gate.sv | 178 +++++++++++++++++
 tb/tb_tlul_err_gate.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_err_gate.sv
// ---------------------------------------------------------------------------
// tlul_err_gate
//
// Sits between a TL-UL host port and a single device port, after the A-channel
// legality checker. Legal A requests are forwarded to the device with zero
// latency, and the number of device transactions in flight is tracked.
// Illegal requests are absorbed. The gate then waits until every earlier
// device response has drained and returns its own D-channel error response,
// so host responses stay in order.
// Data, address and mask fields are routed outside this block. Only control
// and response-header fields are handled here.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   h_a_*                  host A channel (valid/opcode/source/size/err in,
//                          ready out)
//   h_d_*                  host D channel (valid/opcode/source/size/error out,
//                          ready in)
//   dev_a_valid_o          device A valid
//   dev_a_ready_i          device A ready
//   dev_d_*                device D channel (valid/opcode/source/size/error
//                          in, ready out)
//   outstanding_o          device transactions currently in flight
//   proto_err_o            sticky flag: device responded with nothing
//                          outstanding
// ---------------------------------------------------------------------------
module tlul_err_gate #(
  parameter int MaxOutstanding = 4,
  parameter int SrcW           = 8,
  parameter int CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            h_a_valid_i,
  input  logic [2:0]      h_a_opcode_i,
  input  logic [SrcW-1:0] h_a_source_i,
  input  logic [1:0]      h_a_size_i,
  input  logic            h_a_err_i,
  output logic            h_a_ready_o,
  output logic            h_d_valid_o,
  output logic [2:0]      h_d_opcode_o,
  output logic [SrcW-1:0] h_d_source_o,
  output logic [1:0]      h_d_size_o,
  output logic            h_d_error_o,
  input  logic            h_d_ready_i,
  output logic            dev_a_valid_o,
  input  logic            dev_a_ready_i,
  input  logic            dev_d_valid_i,
  input  logic [2:0]      dev_d_opcode_i,
  input  logic [SrcW-1:0] dev_d_source_i,
  input  logic [1:0]      dev_d_size_i,
  input  logic            dev_d_error_i,
  output logic            dev_d_ready_o,
  output logic [CntW-1:0] outstanding_o,
  output logic            proto_err_o
);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StResp
  } state_e;

  localparam logic [2:0] OpGet            = 3'h4;
  localparam logic [2:0] OpAccessAck      = 3'h0;
  localparam logic [2:0] OpAccessAckData  = 3'h1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [2:0]        op_q;
  logic [SrcW-1:0]   src_q;
  logic [1:0]        size_q;
  logic              proto_q;
  logic              capture;
  logic              below_max;
  logic              drain_done;
  logic              a_hs, d_hs;
  logic              proto_set;

  assign below_max = (count_q < CntW'(MaxOutstanding));

  // In DRAIN no A request is forwarded, so the post-update count is zero
  // exactly when it already is zero or the last response is handshaking now.
  // Computed from inputs to keep it independent of the output logic.
  assign drain_done = (count_q == '0) ||
                      ((count_q == CntW'(1)) && dev_d_valid_i && h_d_ready_i);

  // Next state and outputs. The D channel passes through by default and is
  // only replaced by the locally generated error response in RESP. Reset
  // forces every handshake signal low so nothing is exchanged while it is held.
  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    h_a_ready_o   = 1'b0;
    dev_a_valid_o = 1'b0;
    h_d_valid_o   = dev_d_valid_i;
    h_d_opcode_o  = dev_d_opcode_i;
    h_d_source_o  = dev_d_source_i;
    h_d_size_o    = dev_d_size_i;
    h_d_error_o   = dev_d_error_i;
    dev_d_ready_o = h_d_ready_i;

    unique case (state_q)
      StIdle: begin
        if (h_a_valid_i && h_a_err_i) begin
          // Illegal requests are accepted immediately, whatever the count.
          h_a_ready_o = 1'b1;
          capture     = 1'b1;
          state_d     = StDrain;
        end else begin
          dev_a_valid_o = h_a_valid_i & below_max;
          h_a_ready_o   = dev_a_ready_i & below_max;
        end
      end
      StDrain: begin
        if (drain_done) state_d = StResp;
      end
      StResp: begin
        h_d_valid_o   = 1'b1;
        h_d_error_o   = 1'b1;
        h_d_opcode_o  = (op_q == OpGet) ? OpAccessAckData : OpAccessAck;
        h_d_source_o  = src_q;
        h_d_size_o    = size_q;
        dev_d_ready_o = 1'b0;
        if (h_d_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rst_i) begin
      h_a_ready_o   = 1'b0;
      dev_a_valid_o = 1'b0;
      h_d_valid_o   = 1'b0;
      dev_d_ready_o = 1'b0;
    end
  end

  assign a_hs = dev_a_valid_o & dev_a_ready_i;
  assign d_hs = dev_d_valid_i & dev_d_ready_o;

  // Outstanding count. A response with nothing in flight is a device protocol
  // violation: the count stays at zero and the sticky flag is raised. The count
  // cannot overflow because forwarding is gated by below_max.
  always_comb begin
    count_d   = count_q;
    proto_set = d_hs && (count_q == '0);
    if (a_hs && !d_hs) begin
      count_d = count_q + CntW'(1);
    end else if (!a_hs && d_hs && (count_q != '0)) begin
      count_d = count_q - CntW'(1);
    end
  end

  // State, counter, captured header of the absorbed request and sticky flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      count_q <= '0;
      op_q    <= '0;
      src_q   <= '0;
      size_q  <= '0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (proto_set) proto_q <= 1'b1;
      if (capture) begin
        op_q   <= h_a_opcode_i;
        src_q  <= h_a_source_i;
        size_q <= h_a_size_i;
      end
    end
  end

  assign outstanding_o = count_q;
  assign proto_err_o   = proto_q;

endmodule

// File: tb/tb_tlul_err_gate.sv
// ---------------------------------------------------------------------------
// tb_tlul_err_gate
//
// Self-checking bench for tlul_err_gate. It applies a table of directed
// cycles, then hand-written multi-cycle sequences, then randomized traffic
// compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_tlul_err_gate;

  logic       clk = 1'b0;
  logic       rst;
  logic       h_a_valid;
  logic [2:0] h_a_opcode;
  logic [7:0] h_a_source;
  logic [1:0] h_a_size;
  logic       h_a_err;
  logic       h_a_ready;
  logic       h_d_valid;
  logic [2:0] h_d_opcode;
  logic [7:0] h_d_source;
  logic [1:0] h_d_size;
  logic       h_d_error;
  logic       h_d_ready;
  logic       dev_a_valid;
  logic       dev_a_ready;
  logic       dev_d_valid;
  logic [2:0] dev_d_opcode;
  logic [7:0] dev_d_source;
  logic [1:0] dev_d_size;
  logic       dev_d_error;
  logic       dev_d_ready;
  logic [2:0] outstanding;
  logic       proto_err;

  int checkCount = 0;
  int passCount  = 0;

  tlul_err_gate dut (
    .clk_i(clk), .rst_i(rst),
    .h_a_valid_i(h_a_valid), .h_a_opcode_i(h_a_opcode), .h_a_source_i(h_a_source),
    .h_a_size_i(h_a_size), .h_a_err_i(h_a_err), .h_a_ready_o(h_a_ready),
    .h_d_valid_o(h_d_valid), .h_d_opcode_o(h_d_opcode), .h_d_source_o(h_d_source),
    .h_d_size_o(h_d_size), .h_d_error_o(h_d_error), .h_d_ready_i(h_d_ready),
    .dev_a_valid_o(dev_a_valid), .dev_a_ready_i(dev_a_ready),
    .dev_d_valid_i(dev_d_valid), .dev_d_opcode_i(dev_d_opcode),
    .dev_d_source_i(dev_d_source), .dev_d_size_i(dev_d_size),
    .dev_d_error_i(dev_d_error), .dev_d_ready_o(dev_d_ready),
    .outstanding_o(outstanding), .proto_err_o(proto_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       a_valid;
    logic       a_err;
    logic [2:0] a_op;
    logic [7:0] a_src;
    logic [1:0] a_size;
    logic       dev_a_ready;
    logic       d_valid;
    logic [2:0] d_op;
    logic [7:0] d_src;
    logic [1:0] d_size;
    logic       d_err;
    logic       h_d_ready;
    logic       x_h_a_ready;
    logic       x_dev_a_valid;
    logic       x_h_d_valid;
    logic [2:0] x_d_op;
    logic [7:0] x_d_src;
    logic [1:0] x_d_size;
    logic       x_d_err;
    logic       x_dev_d_ready;
    logic [2:0] x_cnt;
    logic       x_proto;
  } vec_t;

  vec_t vecs[21];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    h_a_valid    = v.a_valid;
    h_a_err      = v.a_err;
    h_a_opcode   = v.a_op;
    h_a_source   = v.a_src;
    h_a_size     = v.a_size;
    dev_a_ready  = v.dev_a_ready;
    dev_d_valid  = v.d_valid;
    dev_d_opcode = v.d_op;
    dev_d_source = v.d_src;
    dev_d_size   = v.d_size;
    dev_d_error  = v.d_err;
    h_d_ready    = v.h_d_ready;
  endtask

  task automatic setIdle(input logic hdr);
    rst = 1'b0; h_a_valid = 1'b0; h_a_err = 1'b0; h_a_opcode = '0; h_a_source = '0;
    h_a_size = '0; dev_a_ready = 1'b0; dev_d_valid = 1'b0; dev_d_opcode = '0;
    dev_d_source = '0; dev_d_size = '0; dev_d_error = 1'b0; h_d_ready = hdr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a legal request for a moment inside the cycle and withdraws it
  // well before the next edge, so IDLE can be observed without a handshake.
  task automatic probeIdle(input string name);
    h_a_valid = 1'b1; h_a_err = 1'b0; dev_a_ready = 1'b1;
    #1;
    checkOutput({name, "_h_a_ready"}, 32'(h_a_ready), 32'd1);
    checkOutput({name, "_dev_a_valid"}, 32'(dev_a_valid), 32'd1);
    h_a_valid = 1'b0; dev_a_ready = 1'b0;
  endtask

  // Reference model: in-flight count, sticky flag and one absorbed request
  // that is either still waiting for earlier responses or ready to be sent.
  int         m_cnt;
  bit         m_proto, m_waiting, m_sending;
  logic [2:0] m_op;
  logic [7:0] m_src;
  logic [1:0] m_size;

  initial begin
    // Directed cycles: a legal Get, an illegal Put, then saturation at four.
    //          rst a_v err op  src    sz dar  dv dop dsrc  dsz de hdr  har dav hdv xop xsrc  xsz xe ddr cnt pe
    vecs[0]  = '{0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1,  0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0};
    vecs[1]  = '{0, 1, 0, 4, 8'h11, 2, 1,  0, 0, 8'h00, 0, 0, 1,  1, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1,  0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1,  0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0};
    vecs[4]  = '{0, 0, 0, 0, 8'h00, 0, 0,  1, 1, 8'h11, 2, 0, 1,  0, 0, 1, 1, 8'h11, 2, 0, 1, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1,  0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0};
    vecs[6]  = '{0, 1, 1, 0, 8'h5A, 2, 0,  0, 0, 8'h00, 0, 0, 1,  1, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1,  0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1,  0, 0, 1, 0, 8'h5A, 2, 1, 0, 0, 0};
    vecs[9]  = '{0, 1, 0, 4, 8'h22, 0, 1,  0, 0, 8'h00, 0, 0, 1,  1, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 8'h23, 0, 1,  0, 0, 8'h00, 0, 0, 1,  1, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0};
    vecs[11] = '{0, 1, 0, 0, 8'h24, 0, 1,  0, 0, 8'h00, 0, 0, 1,  1, 1, 0, 0, 8'h00, 0, 0, 1, 2, 0};
    vecs[12] = '{0, 1, 0, 0, 8'h25, 0, 1,  0, 0, 8'h00, 0, 0, 1,  1, 1, 0, 0, 8'h00, 0, 0, 1, 3, 0};
    vecs[13] = '{0, 1, 0, 0, 8'h26, 0, 1,  0, 0, 8'h00, 0, 0, 1,  0, 0, 0, 0, 8'h00, 0, 0, 1, 4, 0};
    vecs[14] = '{0, 1, 0, 0, 8'h26, 0, 1,  1, 1, 8'h22, 0, 0, 1,  0, 0, 1, 1, 8'h22, 0, 0, 1, 4, 0};
    vecs[15] = '{0, 1, 0, 0, 8'h26, 0, 1,  1, 0, 8'h23, 0, 0, 1,  1, 1, 1, 0, 8'h23, 0, 0, 1, 3, 0};
    vecs[16] = '{0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 8'h00, 0, 0, 0, 3, 0};
    vecs[17] = '{0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h24, 0, 0, 1,  0, 0, 1, 0, 8'h24, 0, 0, 1, 3, 0};
    vecs[18] = '{0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h25, 0, 0, 1,  0, 0, 1, 0, 8'h25, 0, 0, 1, 2, 0};
    vecs[19] = '{0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h26, 0, 0, 1,  0, 0, 1, 0, 8'h26, 0, 0, 1, 1, 0};
    vecs[20] = '{0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1,  0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0};

    // Reset, with busy inputs to show the handshake signals are held low.
    setIdle(1'b1);
    rst = 1'b1;
    tick();
    h_a_valid = 1'b1; dev_a_ready = 1'b1; dev_d_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_h_a_ready", 32'(h_a_ready), 32'd0);
    checkOutput("rst_dev_a_valid", 32'(dev_a_valid), 32'd0);
    checkOutput("rst_h_d_valid", 32'(h_d_valid), 32'd0);
    checkOutput("rst_dev_d_ready", 32'(dev_d_ready), 32'd0);
    tick();

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      if (vecs[i].a_valid) checkOutput($sformatf("v%0d_h_a_ready", i), 32'(h_a_ready), 32'(vecs[i].x_h_a_ready));
      checkOutput($sformatf("v%0d_dev_a_valid", i), 32'(dev_a_valid), 32'(vecs[i].x_dev_a_valid));
      checkOutput($sformatf("v%0d_h_d_valid", i), 32'(h_d_valid), 32'(vecs[i].x_h_d_valid));
      if (vecs[i].x_h_d_valid) begin
        checkOutput($sformatf("v%0d_h_d_opcode", i), 32'(h_d_opcode), 32'(vecs[i].x_d_op));
        checkOutput($sformatf("v%0d_h_d_source", i), 32'(h_d_source), 32'(vecs[i].x_d_src));
        checkOutput($sformatf("v%0d_h_d_size", i), 32'(h_d_size), 32'(vecs[i].x_d_size));
        checkOutput($sformatf("v%0d_h_d_error", i), 32'(h_d_error), 32'(vecs[i].x_d_err));
      end
      checkOutput($sformatf("v%0d_dev_d_ready", i), 32'(dev_d_ready), 32'(vecs[i].x_dev_d_ready));
      checkOutput($sformatf("v%0d_outstanding", i), 32'(outstanding), 32'(vecs[i].x_cnt));
      checkOutput($sformatf("v%0d_proto_err", i), 32'(proto_err), 32'(vecs[i].x_proto));
      tick();
    end

    // Illegal Get behind two outstanding requests answered at +4 and +7.
    for (int i = 0; i < 2; i++) begin
      setIdle(1'b1);
      h_a_valid = 1'b1; h_a_opcode = 3'h4; h_a_source = 8'(8'h40 + i); h_a_size = 2'd2;
      dev_a_ready = 1'b1;
      @(negedge clk);
      checkOutput("ord_fwd_dev_a_valid", 32'(dev_a_valid), 32'd1);
      tick();
    end
    setIdle(1'b1);
    h_a_valid = 1'b1; h_a_err = 1'b1; h_a_opcode = 3'h4; h_a_source = 8'h33; h_a_size = 2'd1;
    @(negedge clk);
    checkOutput("ord_accept_h_a_ready", 32'(h_a_ready), 32'd1);
    checkOutput("ord_accept_dev_a_valid", 32'(dev_a_valid), 32'd0);
    checkOutput("ord_accept_outstanding", 32'(outstanding), 32'd2);
    tick();
    for (int t = 1; t <= 7; t++) begin
      bit resp;
      resp = (t == 4) || (t == 7);
      setIdle(1'b1);
      h_a_valid = 1'b1; dev_a_ready = 1'b1;
      if (resp) begin
        dev_d_valid = 1'b1; dev_d_opcode = 3'h1; dev_d_size = 2'd2;
        dev_d_source = (t == 4) ? 8'h40 : 8'h41;
      end
      @(negedge clk);
      checkOutput($sformatf("ord_t%0d_h_a_ready", t), 32'(h_a_ready), 32'd0);
      checkOutput($sformatf("ord_t%0d_dev_a_valid", t), 32'(dev_a_valid), 32'd0);
      checkOutput($sformatf("ord_t%0d_h_d_valid", t), 32'(h_d_valid), 32'(resp));
      if (resp) begin
        checkOutput($sformatf("ord_t%0d_h_d_source", t), 32'(h_d_source), 32'(dev_d_source));
        checkOutput($sformatf("ord_t%0d_h_d_error", t), 32'(h_d_error), 32'd0);
      end
      checkOutput($sformatf("ord_t%0d_outstanding", t), 32'(outstanding), (t <= 4) ? 32'd2 : 32'd1);
      tick();
    end
    // Error response held for two cycles of back-pressure, then taken.
    for (int t = 8; t <= 10; t++) begin
      setIdle(t == 10);
      @(negedge clk);
      checkOutput($sformatf("ord_t%0d_h_d_valid", t), 32'(h_d_valid), 32'd1);
      checkOutput($sformatf("ord_t%0d_h_d_error", t), 32'(h_d_error), 32'd1);
      checkOutput($sformatf("ord_t%0d_h_d_opcode", t), 32'(h_d_opcode), 32'd1);
      checkOutput($sformatf("ord_t%0d_h_d_source", t), 32'(h_d_source), 32'h33);
      checkOutput($sformatf("ord_t%0d_h_d_size", t), 32'(h_d_size), 32'd1);
      checkOutput($sformatf("ord_t%0d_dev_d_ready", t), 32'(dev_d_ready), 32'd0);
      checkOutput($sformatf("ord_t%0d_outstanding", t), 32'(outstanding), 32'd0);
      tick();
    end
    setIdle(1'b1);
    probeIdle("ord_back_idle");
    tick();

    // Spurious device response with nothing outstanding.
    setIdle(1'b1);
    dev_d_valid = 1'b1; dev_d_source = 8'h99;
    @(negedge clk);
    checkOutput("spur_dev_d_ready", 32'(dev_d_ready), 32'd1);
    checkOutput("spur_proto_before", 32'(proto_err), 32'd0);
    tick();
    setIdle(1'b1);
    @(negedge clk);
    checkOutput("spur_proto_set", 32'(proto_err), 32'd1);
    checkOutput("spur_outstanding", 32'(outstanding), 32'd0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("spur_proto_sticky", 32'(proto_err), 32'd1);
    tick();

    // Reset while an error response is waiting on host back-pressure.
    setIdle(1'b0);
    h_a_valid = 1'b1; h_a_err = 1'b1; h_a_opcode = 3'h1; h_a_source = 8'h77; h_a_size = 2'd3;
    tick();
    setIdle(1'b0);
    tick();
    @(negedge clk);
    checkOutput("rresp_h_d_valid", 32'(h_d_valid), 32'd1);
    checkOutput("rresp_h_d_opcode", 32'(h_d_opcode), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rresp_forced_h_d_valid", 32'(h_d_valid), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rresp_after_h_d_valid", 32'(h_d_valid), 32'd0);
    checkOutput("rresp_after_outstanding", 32'(outstanding), 32'd0);
    checkOutput("rresp_after_proto", 32'(proto_err), 32'd0);
    tick();
    probeIdle("rresp_idle");
    tick();

    // Randomized traffic against the reference model.
    setIdle(1'b1);
    rst = 1'b1;
    tick();
    m_cnt = 0; m_proto = 0; m_waiting = 0; m_sending = 0;
    m_op = '0; m_src = '0; m_size = '0;
    for (int c = 0; c < 2000; c++) begin
      bit e_har, e_dav, e_hdv, e_ddr, a_hs, d_hs;
      logic [2:0] e_op;
      logic [7:0] e_src;
      logic [1:0] e_size;
      logic       e_err;
      int         n_cnt;

      rst          = ($urandom_range(0, 199) == 0);
      h_a_valid    = 1'($urandom_range(0, 1));
      h_a_err      = ($urandom_range(0, 7) == 0);
      h_a_opcode   = 3'($urandom_range(0, 7));
      h_a_source   = 8'($urandom);
      h_a_size     = 2'($urandom_range(0, 3));
      dev_a_ready  = ($urandom_range(0, 3) != 0);
      dev_d_valid  = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      dev_d_opcode = 3'($urandom_range(0, 1));
      dev_d_source = 8'($urandom);
      dev_d_size   = 2'($urandom_range(0, 3));
      dev_d_error  = 1'($urandom_range(0, 1));
      h_d_ready    = ($urandom_range(0, 3) != 0);

      // Expected outputs from the model.
      e_har = 0; e_dav = 0;
      e_hdv = dev_d_valid; e_op = dev_d_opcode; e_src = dev_d_source;
      e_size = dev_d_size; e_err = dev_d_error; e_ddr = h_d_ready;
      if (m_sending) begin
        e_hdv = 1; e_err = 1; e_op = (m_op == 3'h4) ? 3'h1 : 3'h0;
        e_src = m_src; e_size = m_size; e_ddr = 0;
      end else if (!m_waiting) begin
        if (h_a_valid && h_a_err) e_har = 1;
        else begin
          e_dav = h_a_valid && (m_cnt < 4);
          e_har = dev_a_ready && (m_cnt < 4);
        end
      end
      if (rst) begin
        e_har = 0; e_dav = 0; e_hdv = 0; e_ddr = 0;
      end

      @(negedge clk);
      if (h_a_valid) checkOutput("rnd_h_a_ready", 32'(h_a_ready), 32'(e_har));
      checkOutput("rnd_dev_a_valid", 32'(dev_a_valid), 32'(e_dav));
      checkOutput("rnd_h_d_valid", 32'(h_d_valid), 32'(e_hdv));
      if (e_hdv) begin
        checkOutput("rnd_h_d_opcode", 32'(h_d_opcode), 32'(e_op));
        checkOutput("rnd_h_d_source", 32'(h_d_source), 32'(e_src));
        checkOutput("rnd_h_d_size", 32'(h_d_size), 32'(e_size));
        checkOutput("rnd_h_d_error", 32'(h_d_error), 32'(e_err));
      end
      checkOutput("rnd_dev_d_ready", 32'(dev_d_ready), 32'(e_ddr));
      checkOutput("rnd_outstanding", 32'(outstanding), 32'(m_cnt));
      checkOutput("rnd_proto_err", 32'(proto_err), 32'(m_proto));

      // Advance the model by one clock edge.
      if (rst) begin
        m_cnt = 0; m_proto = 0; m_waiting = 0; m_sending = 0;
        m_op = '0; m_src = '0; m_size = '0;
      end else begin
        a_hs = e_dav && dev_a_ready;
        d_hs = dev_d_valid && e_ddr;
        if (d_hs && m_cnt == 0) m_proto = 1;
        n_cnt = m_cnt;
        if (a_hs && !d_hs) n_cnt = m_cnt + 1;
        else if (d_hs && !a_hs && m_cnt > 0) n_cnt = m_cnt - 1;
        if (!m_waiting && !m_sending && h_a_valid && h_a_err) begin
          m_waiting = 1; m_op = h_a_opcode; m_src = h_a_source; m_size = h_a_size;
        end else if (m_waiting && n_cnt == 0) begin
          m_waiting = 0; m_sending = 1;
        end else if (m_sending && h_d_ready) begin
          m_sending = 0;
        end
        m_cnt = n_cnt;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
